// File: rtl/zxuno_regbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zxuno_regbus_pkg
// Description : Shared definitions for the ZX-Uno register bus: default I/O
//               port addresses, FSM state encoding, the decoded-access bundle
//               and a helper that maps a decoded access onto its FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
package zxuno_regbus_pkg;

    // Default Z80 I/O addresses of the register-address and register-data ports
    localparam logic [15:0] c_def_addr_port = 16'hFC3B;
    localparam logic [15:0] c_def_data_port = 16'hFD3B;

    // FSM state encoding
    localparam int          c_st_w    = 3;
    localparam logic [2:0]  c_st_idle = 3'd0;
    localparam logic [2:0]  c_st_aw   = 3'd1;
    localparam logic [2:0]  c_st_ar   = 3'd2;
    localparam logic [2:0]  c_st_dw   = 3'd3;
    localparam logic [2:0]  c_st_dr   = 3'd4;

    // One-hot decoded access (at most one bit set)
    typedef struct packed {
        logic aw;   // write to address port
        logic ar;   // read from address port
        logic dw;   // write to data port
        logic dr;   // read from data port
    } acc_t;

    // FSM state corresponding to the access currently on the bus
    function automatic logic [2:0] acc_to_state(input acc_t acc);
        logic [2:0] st;
        st = c_st_idle;
        if (acc.aw) st = c_st_aw;
        if (acc.ar) st = c_st_ar;
        if (acc.dw) st = c_st_dw;
        if (acc.dr) st = c_st_dr;
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zxuno_bus_decode.sv
`default_nettype none
// ============================================================================
// Module      : zxuno_bus_decode
// Description : Purely combinational Z80 I/O decoder. Produces a one-hot
//               {aw, ar, dw, dr} bundle for accesses to the register-address
//               and register-data ports. Both strobes low, or neither low,
//               decodes as no access.
// Ports       : a[15:0]  Z80 address bus
//               iorq_n   I/O request, active-low
//               rd_n     read strobe, active-low
//               wr_n     write strobe, active-low
//               acc      decoded access bundle
// Revision    : 1.0 - initial release
// ============================================================================
module zxuno_bus_decode
    import zxuno_regbus_pkg::*;
#(
    parameter logic [15:0] ADDR_PORT = c_def_addr_port,
    parameter logic [15:0] DATA_PORT = c_def_data_port
) (
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    output acc_t        acc
);

    logic w_io_rd;
    logic w_io_wr;
    logic w_hit_addr;
    logic w_hit_data;

    // Exactly one strobe must be active for a valid access
    assign w_io_rd    = ~iorq_n & ~rd_n &  wr_n;
    assign w_io_wr    = ~iorq_n &  rd_n & ~wr_n;
    assign w_hit_addr = (a == ADDR_PORT);
    assign w_hit_data = (a == DATA_PORT);

    assign acc.aw = w_io_wr & w_hit_addr;
    assign acc.ar = w_io_rd & w_hit_addr;
    assign acc.dw = w_io_wr & w_hit_data;
    assign acc.dr = w_io_rd & w_hit_data;

endmodule
`default_nettype wire

// File: rtl/zxuno_regbus.sv
`default_nettype none
// ============================================================================
// Module      : zxuno_regbus
// Description : ZX-Uno register bus front end. Tracks the selected register
//               address written through ADDR_PORT and generates the strobes
//               that register slaves use for DATA_PORT accesses.
// Ports       : clk, rst            clock, synchronous active-high reset
//               a, iorq_n, rd_n,    Z80 bus (already synchronous to clk)
//               wr_n, din
//               zxuno_addr          selected register address
//               zxuno_regrd         level, high while DATA_PORT is read
//               zxuno_regwr         one-cycle pulse per DATA_PORT write
//               regaddr_changed     one-cycle pulse per ADDR_PORT write
//               dout, oe_n          address read-back bus and its enable
// Config      : ZXUNO_ADDR_READBACK_EN - when defined, reads of ADDR_PORT
//               drive zxuno_addr onto dout; otherwise dout is never driven.
// Revision    : 1.0 - initial release
// ============================================================================
module zxuno_regbus
    import zxuno_regbus_pkg::*;
#(
    parameter logic [15:0] ADDR_PORT = c_def_addr_port,
    parameter logic [15:0] DATA_PORT = c_def_data_port,
    parameter logic [7:0]  RST_ADDR  = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  din,
    output logic [7:0]  zxuno_addr,
    output logic        zxuno_regrd,
    output logic        zxuno_regwr,
    output logic        regaddr_changed,
    output logic [7:0]  dout,
    output logic        oe_n
);

    acc_t               w_acc;
    logic [c_st_w-1:0]  w_decoded;
    logic [c_st_w-1:0]  w_next;
    logic               w_entry;

    logic [c_st_w-1:0]  r_state;
    logic [7:0]         r_addr;
    logic               r_regwr;
    logic               r_changed;
    logic               r_rst_q;

    zxuno_bus_decode #(
        .ADDR_PORT (ADDR_PORT),
        .DATA_PORT (DATA_PORT)
    ) u_decode (
        .a      (a),
        .iorq_n (iorq_n),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .acc    (w_acc)
    );

    always_comb begin
        w_decoded = acc_to_state(w_acc);
        w_next    = r_state;
        if (r_state == c_st_idle) begin
            w_next = w_decoded;
        end else if (w_decoded != r_state) begin
            // Always pass through IDLE so every access gets a fresh entry edge
            w_next = c_st_idle;
        end
    end

    // An entry edge only counts when reset was not active on the previous
    // edge. An access already in flight as reset releases is still tracked
    // (the FSM enters its state) but is blocked: no load, no strobe, and it
    // stays blocked until the access ends and a new one begins.
    assign w_entry = (r_state == c_st_idle) && !r_rst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_addr    <= RST_ADDR;
            r_regwr   <= 1'b0;
            r_changed <= 1'b0;
            r_rst_q   <= 1'b1;
        end else begin
            r_rst_q   <= 1'b0;
            r_state   <= w_next;
            r_regwr   <= w_entry && w_acc.dw;
            r_changed <= w_entry && w_acc.aw;
            if (w_entry && w_acc.aw) begin
                r_addr <= din;
            end
        end
    end

    assign zxuno_addr      = r_addr;
    assign zxuno_regwr     = r_regwr;
    assign regaddr_changed = r_changed;

    // Combinational so slaves see the end of a data read with no latency
    assign zxuno_regrd     = w_acc.dr;

`ifdef ZXUNO_ADDR_READBACK_EN
    assign oe_n = ~w_acc.ar;
    assign dout = w_acc.ar ? r_addr : 8'hzz;
`else
    assign oe_n = 1'b1;
    assign dout = 8'hzz;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zxuno_regbus.sv
`default_nettype none
// ============================================================================
// Module      : tb_zxuno_regbus
// Description : Self-checking bench for zxuno_regbus. Strobe expectations are
//               queued by the stimulus and consumed by an independent monitor;
//               level outputs are checked directly against fixed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zxuno_regbus;

    typedef struct {
        bit         is_wr;   // 1: zxuno_regwr pulse, 0: regaddr_changed pulse
        logic [7:0] addr;    // zxuno_addr expected during the pulse
        int         cyc;     // cycle number in which the pulse must be seen
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  din;
    logic [7:0]  zxuno_addr;
    logic        zxuno_regrd;
    logic        zxuno_regwr;
    logic        regaddr_changed;
    wire  [7:0]  dout;
    logic        oe_n;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    ev_t  exp_q[$];
    ev_t  ev;

    zxuno_regbus dut (
        .clk             (clk),
        .rst             (rst),
        .a               (a),
        .iorq_n          (iorq_n),
        .rd_n            (rd_n),
        .wr_n            (wr_n),
        .din             (din),
        .zxuno_addr      (zxuno_addr),
        .zxuno_regrd     (zxuno_regrd),
        .zxuno_regwr     (zxuno_regwr),
        .regaddr_changed (regaddr_changed),
        .dout            (dout),
        .oe_n            (oe_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the expectation queue
    always @(posedge clk) begin
        #1;
        if (regaddr_changed === 1'b1 && zxuno_regwr === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL strobe_overlap: changed=1 regwr=1 at cycle %0d, required never both", cyc);
        end
        if (regaddr_changed === 1'b1 || zxuno_regwr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: changed=%b regwr=%b at cycle %0d, required no strobe",
                         regaddr_changed, zxuno_regwr, cyc);
            end else begin
                ev = exp_q.pop_front();
                if (zxuno_regwr !== ev.is_wr || regaddr_changed !== !ev.is_wr ||
                    cyc != ev.cyc || zxuno_addr !== ev.addr) begin
                    errors++;
                    $display("FAIL strobe_match: got regwr=%b changed=%b cyc=%0d addr=%h, required regwr=%b cyc=%0d addr=%h",
                             zxuno_regwr, regaddr_changed, cyc, zxuno_addr, ev.is_wr, ev.cyc, ev.addr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic push(input bit is_wr, input logic [7:0] addr);
        ev_t e;
        e.is_wr = is_wr;
        e.addr  = addr;
        e.cyc   = cyc + 1;   // strobe appears after the next rising edge
        exp_q.push_back(e);
    endtask

    task automatic bus_idle();
        a      = 16'h0000;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
    endtask

    task automatic drive(input logic [15:0] addr, input logic rd, input logic wr);
        a      = addr;
        iorq_n = 1'b0;
        rd_n   = ~rd;
        wr_n   = ~wr;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        din = 8'h00;
        bus_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_addr",    zxuno_addr,             8'h00);
        chk("rst_regwr",   {7'd0, zxuno_regwr},    8'h00);
        chk("rst_changed", {7'd0, regaddr_changed}, 8'h00);
        chk("rst_regrd",   {7'd0, zxuno_regrd},    8'h00);
        chk("rst_oe_n",    {7'd0, oe_n},           8'h01);

        // Address write FF held 3 cycles: one pulse, address loaded
        din = 8'hFF;
        drive(16'hFC3B, 1'b0, 1'b1);
        push(1'b0, 8'hFF);
        @(negedge clk);
        chk("aw_addr_load", zxuno_addr, 8'hFF);
        repeat (2) @(negedge clk);
        bus_idle();

        // Same-value rewrite after 2 idle cycles still pulses
        repeat (2) @(negedge clk);
        drive(16'hFC3B, 1'b0, 1'b1);
        push(1'b0, 8'hFF);
        @(negedge clk);
        chk("aw_same_addr", zxuno_addr, 8'hFF);
        repeat (2) @(negedge clk);
        bus_idle();
        @(negedge clk);

        // Data read 4 cycles: regrd level tracks rd_n with zero latency
        drive(16'hFD3B, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("dr_regrd_hi", {7'd0, zxuno_regrd}, 8'h01);
            chk("dr_oe_n",     {7'd0, oe_n},        8'h01);
            @(negedge clk);
        end
        bus_idle();
        #1;
        chk("dr_regrd_fall", {7'd0, zxuno_regrd}, 8'h00);
        @(negedge clk);

        // Data write 5A held 5 cycles: exactly one regwr pulse
        din = 8'h5A;
        drive(16'hFD3B, 1'b0, 1'b1);
        push(1'b1, 8'hFF);
        repeat (5) @(negedge clk);
        bus_idle();
        @(negedge clk);

        // Both strobes low at FC3B: no access
        din = 8'h33;
        drive(16'hFC3B, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("conflict_addr", zxuno_addr,          8'hFF);
        chk("conflict_oe_n", {7'd0, oe_n},        8'h01);
        bus_idle();
        @(negedge clk);

        // Load 0B, then read back the address port
        din = 8'h0B;
        drive(16'hFC3B, 1'b0, 1'b1);
        push(1'b0, 8'h0B);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        chk("ar_prep_addr", zxuno_addr, 8'h0B);
        drive(16'hFC3B, 1'b1, 1'b0);
        #1;
`ifdef ZXUNO_ADDR_READBACK_EN
        chk("ar_oe_n", {7'd0, oe_n}, 8'h00);
        chk("ar_dout", dout,         8'h0B);
`else
        chk("ar_oe_n", {7'd0, oe_n}, 8'h01);
`endif
        chk("ar_regrd", {7'd0, zxuno_regrd}, 8'h00);
        @(negedge clk);
        bus_idle();
        #1;
        chk("ar_end_oe_n", {7'd0, oe_n}, 8'h01);
        @(negedge clk);

        // Reset across an address write: blocked until a fresh access
        rst = 1'b1;
        din = 8'h77;
        drive(16'hFC3B, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_aw_addr", zxuno_addr, 8'h00);
        bus_idle();
        @(negedge clk);
        chk("rst_aw_after", zxuno_addr, 8'h00);
        din = 8'h21;
        drive(16'hFC3B, 1'b0, 1'b1);
        push(1'b0, 8'h21);
        @(negedge clk);
        chk("fresh_aw_addr", zxuno_addr, 8'h21);
        bus_idle();
        @(negedge clk);

        // Reset across a data write: no regwr until a fresh write
        rst = 1'b1;
        din = 8'hA5;
        drive(16'hFD3B, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus_idle();
        @(negedge clk);
        drive(16'hFD3B, 1'b0, 1'b1);
        push(1'b1, 8'h00);
        repeat (2) @(negedge clk);
        bus_idle();
        @(negedge clk);

        // regrd follows decode while reset is held
        rst = 1'b1;
        drive(16'hFD3B, 1'b1, 1'b0);
        #1;
        chk("rst_dr_regrd", {7'd0, zxuno_regrd}, 8'h01);
        @(negedge clk);
        bus_idle();
        rst = 1'b0;
        repeat (3) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL strobe_missing: %0d expected strobes not seen, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zxuno_regbus.md
ZXUNO_REGBUS -- requirements
Module: zxuno_regbus

Interface
- REQ-001 Parameter ADDR_PORT, default 16'hFC3B: I/O address of the register-address port.
- REQ-002 Parameter DATA_PORT, default 16'hFD3B: I/O address of the register-data port.
- REQ-003 Parameter RST_ADDR, default 8'h00: register address loaded at reset.
- REQ-004 clk  in  1  system clock; single clock domain; all Z80 bus inputs are already synchronous to clk.
- REQ-005 rst  in  1  reset, synchronous, active-high.
- REQ-006 a  in  16  Z80 address bus.
- REQ-007 iorq_n, rd_n, wr_n  in  1 each  Z80 I/O strobes, active-low.
- REQ-008 din  in  8  Z80 data bus (write data).
- REQ-009 zxuno_addr  out  8  currently selected register address.
- REQ-010 zxuno_regrd  out  1  level, high while a read of DATA_PORT is in progress.
- REQ-011 zxuno_regwr  out  1  one-cycle pulse per write to DATA_PORT.
- REQ-012 regaddr_changed  out  1  one-cycle pulse per write to ADDR_PORT.
- REQ-013 dout  out  8  read-back data; 8'hZZ when oe_n is high.
- REQ-014 oe_n  out  1  active-low; low while this block drives dout.

Function
- REQ-015 Decode: the four access types are AW (write ADDR_PORT), AR (read ADDR_PORT), DW (write DATA_PORT) and DR (read DATA_PORT); each requires iorq_n=0, a full 16-bit address match, and exactly one of rd_n/wr_n low.
- REQ-016 An access with rd_n=0 and wr_n=0 together, or with neither low, SHALL decode as no access.
- REQ-017 The FSM SHALL have states IDLE, AW, AR, DW and DR.
- REQ-018 From IDLE, the FSM SHALL enter the state of the decoded access on the first clk edge the access is seen.
- REQ-019 From any non-IDLE state, the FSM SHALL return to IDLE on the first clk edge the decode no longer matches that state.
- REQ-020 No direct transition between two non-IDLE states SHALL occur.
- REQ-021 On the IDLE->AW edge, zxuno_addr SHALL load din.
- REQ-022 regaddr_changed SHALL be high for exactly the following cycle.
- REQ-023 regaddr_changed SHALL pulse even when the written value equals the current zxuno_addr.
- REQ-024 On the IDLE->DW edge, zxuno_regwr SHALL pulse high for exactly one cycle.
- REQ-025 A DW access held for N cycles SHALL produce exactly one regwr pulse.
- REQ-026 zxuno_regrd SHALL be combinational: high whenever DR decodes true, independent of FSM state, so that downstream consumers see the trailing edge with zero latency.
- REQ-027 zxuno_regwr and regaddr_changed SHALL never be high in the same cycle.
- REQ-028 zxuno_addr SHALL be stable except on the AW entry edge and reset.

Reset
- REQ-029 On rst=1 at a clk edge: zxuno_addr=RST_ADDR, FSM=IDLE, zxuno_regwr=0, regaddr_changed=0.
- REQ-030 During reset, oe_n, dout and zxuno_regrd SHALL follow decode only.
- REQ-031 If an AW or DW access is active in the cycle rst deasserts, the FSM SHALL go to a blocked state equivalent to that access, and SHALL emit no strobe until the access ends and a new access begins.

Configuration
- REQ-032 Macro ZXUNO_ADDR_READBACK_EN defined: during AR, oe_n=0 and dout=zxuno_addr.
- REQ-033 Macro ZXUNO_ADDR_READBACK_EN undefined: oe_n SHALL stay 1 for AR, and the AR state SHALL still be tracked.
- REQ-034 DR read data SHALL never be driven by this block; regardless of the macro, it comes from the register slaves.

Structure
- REQ-035 Package zxuno_regbus_pkg SHALL hold the FSM state encoding and the default port constants 16'hFC3B and 16'hFD3B.
- REQ-036 Sub-module zxuno_bus_decode SHALL be purely combinational, mapping a, iorq_n, rd_n and wr_n to one-hot {aw, ar, dw, dr}.

Verification
- REQ-037 Address write: write 8'hFF to FC3B for 3 cycles -> zxuno_addr=FF from cycle 1; regaddr_changed high in cycle 2 only; zxuno_regwr never high.
- REQ-038 Same-value rewrite: write FF to FC3B twice, separated by 2 idle cycles -> two regaddr_changed pulses; zxuno_addr unchanged at FF.
- REQ-039 Data read: read FD3B for 4 cycles, then release -> zxuno_regrd high for exactly those 4 cycles, falling in the same cycle as rd_n; oe_n stays 1.
- REQ-040 Data write: write 8'h5A to FD3B for 5 cycles -> exactly one zxuno_regwr pulse, in cycle 2.
- REQ-041 Conflicts: iorq_n=0, rd_n=0 and wr_n=0 at FC3B -> no strobe and no address change; assert rst during an AW and deassert mid-access -> zxuno_addr=00 and no regaddr_changed until the next fresh AW.
- REQ-042 Readback with the macro defined: zxuno_addr=8'h0B, read FC3B -> oe_n=0 and dout=0B; without the macro -> oe_n=1 and dout=Z.
